// File: rtl/pattern_recorder_pkg.sv
// pattern_recorder shared definitions: state encoding and
// default entry geometry, common with the LED pattern player.
package pattern_recorder_pkg;

    localparam int DEF_WIDTH     = 5;
    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_DIV_BITS  = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_recorder_if.sv
// Button/record-control/read-port bundle between the board side
// (master) and the recorder (slave).
interface pattern_recorder_if
    import pattern_recorder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS
);

    logic [WIDTH-1:0]     BUTTONS;
    logic                 REC_START;
    logic                 REC_STOP;
    logic [ADDR_BITS-1:0] RD_ADDR;
    logic [WIDTH-1:0]     RD_DATA;
    logic [ADDR_BITS:0]   LENGTH;
    logic                 RECORDING;
    logic                 FULL;

    modport master (
        output BUTTONS,
        output REC_START,
        output REC_STOP,
        output RD_ADDR,
        input  RD_DATA,
        input  LENGTH,
        input  RECORDING,
        input  FULL
    );

    modport slave (
        input  BUTTONS,
        input  REC_START,
        input  REC_STOP,
        input  RD_ADDR,
        output RD_DATA,
        output LENGTH,
        output RECORDING,
        output FULL
    );

endinterface

// File: rtl/pattern_recorder_sync_bits.sv
// Two-flop synchronizer for asynchronous button levels.
module sync_bits #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pattern_recorder.sv
// Samples synchronized buttons on a prescaled tick into a small
// pattern memory with a registered read port.
module pattern_recorder
    import pattern_recorder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DIV_BITS  = DEF_DIV_BITS
) (
    input  logic               CLK,
    input  logic               RESET,
    pattern_recorder_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] LEN_FULL =
        {1'b1, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0]     sample;
    state_e               state_q, state_d;
    logic [DIV_BITS-1:0]  presc_q, presc_d;
    logic [ADDR_BITS:0]   len_q, len_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 tick;
    logic                 we;
    logic [ADDR_BITS-1:0] wr_ptr;

    sync_bits #(.W(WIDTH)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (bus.BUTTONS),
        .q   (sample)
    );

    assign tick   = (presc_q == '0);
    // Entries are written densely from 0, so the count doubles as the pointer.
    assign wr_ptr = len_q[ADDR_BITS-1:0];

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        len_d   = len_q;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.REC_START) begin
                    state_d = ST_RECORD;
                    presc_d = '0;
                    len_d   = '0;
                end
            end
            ST_RECORD: begin
                presc_d = presc_q + 1'b1;
                if (bus.REC_START) begin
                    presc_d = '0;
                    len_d   = '0;
                end else begin
                    if (tick) begin
                        we    = 1'b1;
                        len_d = len_q + 1'b1;
                    end
                    if (bus.REC_STOP || len_d == LEN_FULL) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[wr_ptr] <= sample;
        end
    end

    assign rd_data_d = mem_q[bus.RD_ADDR];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.RD_DATA   = rd_data_q;
    assign bus.LENGTH    = len_q;
    assign bus.RECORDING = (state_q == ST_RECORD);
    assign bus.FULL      = (len_q == LEN_FULL);

endmodule

// File: tb/tb_pattern_recorder.sv
// Directed bench: a 16-deep and a 4-deep recorder, tick every 4 cycles.
module tb_pattern_recorder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pattern_recorder_if #(.WIDTH(5), .ADDR_BITS(4)) a_if ();
    pattern_recorder_if #(.WIDTH(5), .ADDR_BITS(2)) b_if ();

    pattern_recorder #(
        .WIDTH(5), .ADDR_BITS(4), .DIV_BITS(2)
    ) u_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (a_if)
    );

    pattern_recorder #(
        .WIDTH(5), .ADDR_BITS(2), .DIV_BITS(2)
    ) u_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_a(input logic [3:0] addr,
                        input logic [4:0] exp,
                        input string tag);
        a_if.RD_ADDR = addr;
        step(1);
        check(tag, 32'(a_if.RD_DATA), 32'(exp));
    endtask

    task automatic rd_b(input logic [1:0] addr,
                        input logic [4:0] exp,
                        input string tag);
        b_if.RD_ADDR = addr;
        step(1);
        check(tag, 32'(b_if.RD_DATA), 32'(exp));
    endtask

    task automatic pulse_a_start();
        a_if.REC_START = 1'b1;
        step(1);
        a_if.REC_START = 1'b0;
    endtask

    task automatic pulse_a_stop();
        a_if.REC_STOP = 1'b1;
        step(1);
        a_if.REC_STOP = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a_if.BUTTONS = '0;
        a_if.REC_START = 1'b0;
        a_if.REC_STOP = 1'b0;
        a_if.RD_ADDR = '0;
        b_if.BUTTONS = '0;
        b_if.REC_START = 1'b0;
        b_if.REC_STOP = 1'b0;
        b_if.RD_ADDR = '0;

        step(3);
        check("rst_len", 32'(a_if.LENGTH), 0);
        check("rst_rec", 32'(a_if.RECORDING), 0);
        check("rst_full", 32'(a_if.FULL), 0);
        check("rst_rd", 32'(a_if.RD_DATA), 0);
        check("rst_b_full", 32'(b_if.FULL), 0);
        check("rst_b_len", 32'(b_if.LENGTH), 0);
        rst = 1'b0;

        // basic capture, STOP one cycle after the third write
        a_if.BUTTONS = 5'b00001;
        step(3);
        a_if.BUTTONS = 5'b00100;
        step(6);
        pulse_a_start();
        check("start_rec", 32'(a_if.RECORDING), 1);
        check("start_len", 32'(a_if.LENGTH), 0);
        a_if.BUTTONS = 5'b01010;
        step(1);
        check("w1_len", 32'(a_if.LENGTH), 1);
        step(3);
        a_if.BUTTONS = 5'b10001;
        step(1);
        check("w2_len", 32'(a_if.LENGTH), 2);
        step(3);
        check("pre_w3_len", 32'(a_if.LENGTH), 2);
        step(1);
        check("w3_len", 32'(a_if.LENGTH), 3);
        check("w3_full", 32'(a_if.FULL), 0);
        pulse_a_stop();
        check("stop_len", 32'(a_if.LENGTH), 3);
        check("stop_rec", 32'(a_if.RECORDING), 0);
        rd_a(4'd0, 5'b00100, "rd0");
        rd_a(4'd1, 5'b01010, "rd1");
        rd_a(4'd2, 5'b10001, "rd2");

        // STOP on a tick cycle still writes that sample
        a_if.BUTTONS = 5'b00111;
        step(3);
        pulse_a_start();
        check("ts_rec", 32'(a_if.RECORDING), 1);
        step(1);
        check("ts_w1", 32'(a_if.LENGTH), 1);
        step(3);
        pulse_a_stop();
        check("ts_len", 32'(a_if.LENGTH), 2);
        check("ts_rec_off", 32'(a_if.RECORDING), 0);
        step(4);
        check("ts_hold", 32'(a_if.LENGTH), 2);
        rd_a(4'd1, 5'b00111, "ts_rd1");

        // START+STOP together in DONE: START wins
        a_if.REC_START = 1'b1;
        a_if.REC_STOP = 1'b1;
        step(1);
        a_if.REC_START = 1'b0;
        a_if.REC_STOP = 1'b0;
        check("ss_rec", 32'(a_if.RECORDING), 1);
        check("ss_len", 32'(a_if.LENGTH), 0);
        step(1);
        check("ss_w1", 32'(a_if.LENGTH), 1);
        a_if.BUTTONS = 5'b11000;
        step(4);
        check("ss_w2", 32'(a_if.LENGTH), 2);

        // restart mid-record: next write goes to address 0
        pulse_a_start();
        check("rs_len", 32'(a_if.LENGTH), 0);
        check("rs_rec", 32'(a_if.RECORDING), 1);
        step(1);
        check("rs_w1", 32'(a_if.LENGTH), 1);
        rd_a(4'd0, 5'b11000, "rs_rd0");
        step(3);
        check("rs_w2", 32'(a_if.LENGTH), 2);

        // reset mid-record, memory survives
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mr_rec", 32'(a_if.RECORDING), 0);
        check("mr_len", 32'(a_if.LENGTH), 0);
        pulse_a_stop();
        check("mr_stop_rec", 32'(a_if.RECORDING), 0);
        check("mr_stop_len", 32'(a_if.LENGTH), 0);
        step(5);
        check("mr_idle_len", 32'(a_if.LENGTH), 0);
        rd_a(4'd0, 5'b11000, "mr_rd0");

        // fill the 4-deep instance
        b_if.BUTTONS = 5'b00011;
        step(3);
        b_if.REC_START = 1'b1;
        step(1);
        b_if.REC_START = 1'b0;
        b_if.BUTTONS = 5'b01100;
        check("f_rec", 32'(b_if.RECORDING), 1);
        step(12);
        check("f_len3", 32'(b_if.LENGTH), 3);
        check("f_full3", 32'(b_if.FULL), 0);
        check("f_rec3", 32'(b_if.RECORDING), 1);
        step(1);
        check("f_len4", 32'(b_if.LENGTH), 4);
        check("f_full4", 32'(b_if.FULL), 1);
        check("f_rec4", 32'(b_if.RECORDING), 0);
        step(10);
        check("f_hold_len", 32'(b_if.LENGTH), 4);
        check("f_hold_full", 32'(b_if.FULL), 1);
        rd_b(2'd0, 5'b00011, "f_rd0");
        rd_b(2'd1, 5'b01100, "f_rd1");
        rd_b(2'd3, 5'b01100, "f_rd3");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_recorder.md
# pattern_recorder

Capture-side counterpart to the LED pattern player. Samples a 5-bit button input on a prescaled tick and writes each sample into an internal pattern memory, producing a sequence the player-style SOC can read back and drive onto `LEDS`. Sits between the board button pins and the SOC; owns the memory write side and exposes a registered read port.

## Interface

**Parameters**
- `WIDTH`, 5: bits per pattern entry (button count).
- `ADDR_BITS`, 4: memory address width; depth = 2^ADDR_BITS = 16.
- `DIV_BITS`, 21: prescaler width; sample period = 2^DIV_BITS cycles.

**Ports** (clock and reset first)
- `CLK` in 1: single clock, all logic on posedge.
- `RESET` in 1: synchronous, active-high.
- `BUTTONS` in WIDTH: raw, asynchronous button levels.
- `REC_START` in 1: single-cycle pulse, start or restart recording.
- `REC_STOP` in 1: single-cycle pulse, end recording.
- `RD_ADDR` in ADDR_BITS: read address.
- `RD_DATA` out WIDTH: `MEM[RD_ADDR]`, registered.
- `LENGTH` out ADDR_BITS+1: number of valid entries, 0..16.
- `RECORDING` out 1: high in RECORD state.
- `FULL` out 1: high when LENGTH == 2^ADDR_BITS.

## Operation

- **Input sync:** `BUTTONS` passes through a 2-flop synchronizer. `sample` = output of the second stage.
- **FSM states:** IDLE, RECORD, DONE.
  - **IDLE**
    - REC_START → RECORD: wr_ptr=0, LENGTH=0, prescaler=0.
    - REC_STOP ignored.
  - **RECORD**
    - Prescaler increments every cycle.
    - tick = (prescaler == 0).
    - On tick: `MEM[wr_ptr] <= sample`, wr_ptr++, LENGTH++.
    - A tick write that makes LENGTH == 2^ADDR_BITS → DONE.
    - REC_STOP → DONE.
  - **DONE**
    - REC_START → RECORD with the same clears as from IDLE.
    - REC_STOP ignored.
- **Simultaneous / repeat events:**
  - REC_START in RECORD restarts: LENGTH=0, prescaler=0. Any tick write in that cycle is discarded.
  - REC_START and REC_STOP together: START wins.
  - Tick and REC_STOP together: the write happens, LENGTH increments, then DONE.
- **Wrap-around:** wr_ptr never wraps. Recording halts at full; no overwrite.
- **Read port:** active in every state.
  - `RD_DATA <= MEM[RD_ADDR]` each cycle.
  - Same-cycle read and write at the same address returns old data.
  - Contents at addresses ≥ LENGTH are unspecified.
- **Outputs:** RECORDING = (state==RECORD). FULL is combinational from LENGTH.

## Timing

- **Reset values:** state=IDLE, LENGTH=0, RECORDING=0, FULL=0, RD_DATA=0, sync flops=0, prescaler=0. MEM is not cleared.
- **Reset mid-record:** aborts and returns to IDLE with LENGTH=0. Memory keeps partial data.
- **Input latency:** a BUTTONS change is visible in `sample` 2 cycles later.
- **Start:** REC_START sampled high at edge N → RECORDING=1 after edge N.
  - First write at edge N+1 (prescaler==0).
  - Subsequent writes at N+1+k·2^DIV_BITS.
  - LENGTH updates on the same edge as each write.
- **Stop:** REC_STOP at edge M → RECORDING=0 after M.
- **Full:** FULL rises on the edge of the 16th write. RECORDING falls on that same edge.
- **Read latency:** 1 cycle. RD_ADDR presented before edge K → RD_DATA valid after K.

## Structure

- **Shared header** `pattern_defs.vh`:
  - State encodings (IDLE=2'd0, RECORD=2'd1, DONE=2'd2).
  - Default WIDTH and ADDR_BITS, shared with the LED player so both ends agree on entry width and depth.
- **Sub-module** `sync_bits #(.W(WIDTH))`: 2-flop synchronizer with synchronous RESET.
- **Memory:** inferred as a reg array with one write port and one registered read port (BRAM-friendly). No reset on the array.
- **Prescaler:** internal counter. Do not reuse the divided-clock block; everything runs on `CLK` with a tick enable.

## Test plan

Run with DIV_BITS=2 (tick every 4 cycles) unless noted.

- **Reset:** RESET high 3 cycles → LENGTH=0, RECORDING=0, FULL=0, RD_DATA=0.
- **Basic capture:**
  - Stimulus: BUTTONS=5'b00001, then 5'b00100 held ≥6 cycles, REC_START pulse, REC_STOP after 3 ticks.
  - Required response: LENGTH=3; reads of addr 0..2 return the synchronized values present at each tick; RECORDING low after STOP.
- **Fill to full (ADDR_BITS=2):**
  - Stimulus: record with no STOP.
  - Required response: FULL=1 and RECORDING=0 on the 4th write; LENGTH=4; later ticks never write; MEM[0] unchanged.
- **Simultaneous events:**
  - Tick-cycle STOP → that sample is written, LENGTH increments.
  - START+STOP in the same cycle during DONE → RECORD with LENGTH=0.
- **Restart mid-record:** REC_START after 2 writes → LENGTH=0; next write lands at addr 0 on the following cycle.
- **Reset mid-record:** RESET during RECORD with LENGTH=2 → IDLE, LENGTH=0; REC_STOP afterwards has no effect.
